data_memory_pipe: RTL and testbench

DATA_MEMORY_PIPE -- requirements
Module: data_memory_pipe

---
 rtl/data_memory_pipe.sv | 98 +++++++++
 tb/tb_data_memory_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_pipe.sv
// data_memory_pipe: single-transaction data memory with LAT-cycle response and sticky processor status.
// Define DMEM_ALIGN_CHECK_EN to flag req_addr[2:0] != 0 as an access error.
module data_memory_pipe #(
    parameter int DEPTH  = 8192,
    parameter int ADDR_W = 64,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [3:0]        icode,
    input  logic              instr_valid,
    input  logic              imem_error,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic [2:0]        stat
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [2:0]  stat_q, stat_d;
    logic [63:0] mem [DEPTH];
    logic [ADDR_W-1:0] widx;
    logic        accept, acc_err, we;
    logic [2:0]  new_stat;

    assign widx = req_addr >> 3;
`ifdef DMEM_ALIGN_CHECK_EN
    assign acc_err = (widx >= DEPTH_A) || (req_addr[2:0] != 3'd0);
`else
    logic unused_lo;
    assign unused_lo = ^req_addr[2:0];
    assign acc_err = widx >= DEPTH_A;
`endif
    assign accept   = (state_q == IDLE) && req_valid;
    assign we       = accept && req_write && !acc_err && instr_valid && !imem_error;
    assign new_stat = !instr_valid ? INS : (imem_error || acc_err) ? ADR : (icode == 4'd0) ? HLT : AOK;

    assign req_ready  = state_q == IDLE;
    assign resp_valid = state_q == RESP;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign stat       = stat_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        stat_d  = stat_q;
        if (accept) begin
            state_d = (LAT == 1) ? RESP : BUSY;
            cnt_d   = 3'(LAT - 1);
            rdata_d = (req_write || acc_err) ? 64'd0 : mem[widx[IW-1:0]];
            err_d   = acc_err;
            stat_d  = (stat_q != AOK) ? stat_q : new_stat;
        end else if (state_q == BUSY) begin
            cnt_d   = cnt_q - 3'd1;
            state_d = (cnt_q == 3'd1) ? RESP : BUSY;
        end else if (state_q == RESP && resp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
            stat_q  <= AOK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            stat_q  <= stat_d;
        end
    end

    // array is deliberately outside reset so committed stores survive it
    always_ff @(posedge clk) begin
        if (we) mem[widx[IW-1:0]] <= req_wdata;
    end
endmodule

// File: tb/tb_data_memory_pipe.sv
// tb_data_memory_pipe: three DUTs (LAT 1, 3, 4) driven by directed and random transactions
// and checked against an array-based reference model of memory contents and sticky status.
module tb_data_memory_pipe;
    localparam int DEPTH = 8192;
    localparam int ND = 3;

    logic        clk, rst;
    logic        req_valid [ND], req_ready [ND], req_write [ND];
    logic [63:0] req_addr [ND], req_wdata [ND], resp_rdata [ND];
    logic [3:0]  icode [ND];
    logic        instr_valid [ND], imem_error [ND];
    logic        resp_valid [ND], resp_ready [ND], resp_err [ND];
    logic [2:0]  stat [ND];

    logic [63:0] mdl_mem [ND][64];
    logic [2:0]  mdl_stat [ND];
    int checks = 0, failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        data_memory_pipe #(.DEPTH(DEPTH), .ADDR_W(64), .LAT(g == 0 ? 1 : g == 1 ? 3 : 4)) u_dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_write(req_write[g]),
            .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .icode(icode[g]), .instr_valid(instr_valid[g]), .imem_error(imem_error[g]),
            .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]), .resp_err(resp_err[g]), .stat(stat[g])
        );
    end

    function automatic int lat_of(input int d);
        return d == 0 ? 1 : d == 1 ? 3 : 4;
    endfunction

    function automatic logic exp_err(input logic [63:0] a);
        logic e;
        e = (a >> 3) >= 64'(DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
        e = e || (a[2:0] != 3'd0);
`endif
        return e;
    endfunction

    function automatic logic [2:0] status_of(input logic iv, input logic ie, input logic ae, input logic [3:0] ic);
        if (!iv) return 3'd4;
        if (ie || ae) return 3'd3;
        if (ic == 4'd0) return 3'd2;
        return 3'd1;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int d = 0; d < ND; d++) begin
            req_valid[d] = 1'b0;
            resp_ready[d] = 1'b0;
            mdl_stat[d] = 3'd1;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic txn(input int d, input logic w, input logic [63:0] a, input logic [63:0] wd,
                       input logic [3:0] ic, input logic iv, input logic ie, input int hold);
        logic [63:0] er;
        logic ee;
        int lat;
        lat = lat_of(d);
        ee = exp_err(a);
        er = (w || ee) ? 64'd0 : mdl_mem[d][a[8:3]];
        @(negedge clk);
        checks++;
        if (req_ready[d] !== 1'b1) begin
            failures++;
            $display("FAIL idle_ready d=%0d got=%b exp=1", d, req_ready[d]);
        end
        req_valid[d] = 1'b1; req_write[d] = w; req_addr[d] = a; req_wdata[d] = wd;
        icode[d] = ic; instr_valid[d] = iv; imem_error[d] = ie; resp_ready[d] = 1'b0;
        @(posedge clk);
        if (w && !ee && iv && !ie) mdl_mem[d][a[8:3]] = wd;
        if (mdl_stat[d] == 3'd1) mdl_stat[d] = status_of(iv, ie, ee, ic);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            req_valid[d] = 1'($urandom_range(0, 1));
            req_write[d] = 1'b1;
            req_wdata[d] = ~wd;
            checks++;
            if (resp_valid[d] !== (k == lat) || req_ready[d] !== 1'b0) begin
                failures++;
                $display("FAIL latency d=%0d k=%0d got_valid=%b got_ready=%b exp_valid=%b exp_ready=0",
                         d, k, resp_valid[d], req_ready[d], k == lat);
            end
        end
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            checks++;
            if (resp_valid[d] !== 1'b1 || resp_rdata[d] !== er || resp_err[d] !== ee ||
                stat[d] !== mdl_stat[d] || req_ready[d] !== 1'b0) begin
                failures++;
                $display("FAIL response d=%0d h=%0d got v=%b data=%h err=%b stat=%0d rdy=%b exp v=1 data=%h err=%b stat=%0d rdy=0",
                         d, h, resp_valid[d], resp_rdata[d], resp_err[d], stat[d], req_ready[d], er, ee, mdl_stat[d]);
            end
            resp_ready[d] = (h == hold);
        end
        req_valid[d] = 1'b0;
        @(negedge clk);
        resp_ready[d] = 1'b0;
        checks++;
        if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            failures++;
            $display("FAIL handshake d=%0d got v=%b rdy=%b exp v=0 rdy=1", d, resp_valid[d], req_ready[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < ND; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
            icode[d] = 4'd1; instr_valid[d] = 1'b1; imem_error[d] = 1'b0; resp_ready[d] = 1'b0;
            mdl_stat[d] = 3'd1;
        end
        #23;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (resp_valid[d] !== 1'b0 || resp_rdata[d] !== 64'd0 || resp_err[d] !== 1'b0 ||
                stat[d] !== 3'd1 || req_ready[d] !== 1'b1) begin
                failures++;
                $display("FAIL reset d=%0d got v=%b data=%h err=%b stat=%0d rdy=%b exp v=0 data=0 err=0 stat=1 rdy=1",
                         d, resp_valid[d], resp_rdata[d], resp_err[d], stat[d], req_ready[d]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int d = 0; d < ND; d++)
            for (int i = 0; i < 64; i++)
                txn(d, 1'b1, 64'(i) << 3, {$urandom, $urandom}, 4'd5, 1'b1, 1'b0, 0);
    endtask

    task automatic test_basic();
        txn(0, 1'b1, 64'h40, 64'h1122334455667788, 4'd4, 1'b1, 1'b0, 0);
        txn(0, 1'b0, 64'h40, 64'd0, 4'd5, 1'b1, 1'b0, 0);
    endtask

    task automatic test_stall();
        txn(1, 1'b1, 64'h48, 64'hDEADBEEFCAFEF00D, 4'd4, 1'b1, 1'b0, 2);
        txn(1, 1'b0, 64'h48, 64'd0, 4'd5, 1'b1, 1'b0, 5);
    endtask

    task automatic test_oob();
        for (int d = 0; d < ND; d++) begin
            txn(d, 1'b0, 64'(DEPTH) * 8, 64'd0, 4'd5, 1'b1, 1'b0, 1);
            txn(d, 1'b0, 64'h8, 64'd0, 4'd0, 1'b1, 1'b0, 0);
            txn(d, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1234, 4'd4, 1'b1, 1'b0, 0);
        end
        apply_reset();
    endtask

    task automatic test_ins();
        txn(0, 1'b1, 64'h8, 64'hFF, 4'd4, 1'b0, 1'b0, 0);
        txn(0, 1'b0, 64'h8, 64'd0, 4'd5, 1'b1, 1'b0, 0);
        apply_reset();
        txn(2, 1'b1, 64'h18, 64'hABCD, 4'd4, 1'b1, 1'b1, 0);
        txn(2, 1'b0, 64'h18, 64'd0, 4'd5, 1'b1, 1'b0, 0);
        apply_reset();
    endtask

    task automatic test_align();
        for (int d = 0; d < ND; d++) begin
            txn(d, 1'b0, 64'h43, 64'd0, 4'd5, 1'b1, 1'b0, 0);
            apply_reset();
        end
    endtask

    task automatic test_reset_busy();
        logic [63:0] v;
        v = {$urandom, $urandom};
        txn(2, 1'b1, 64'h10, v, 4'd4, 1'b1, 1'b0, 0);
        @(negedge clk);
        req_valid[2] = 1'b1; req_write[2] = 1'b0; req_addr[2] = 64'h10;
        icode[2] = 4'd0; instr_valid[2] = 1'b1; imem_error[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        checks++;
        if (resp_valid[2] !== 1'b0 || stat[2] !== 3'd2) begin
            failures++;
            $display("FAIL busy_state got v=%b stat=%0d exp v=0 stat=2", resp_valid[2], stat[2]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (resp_valid[2] !== 1'b0 || stat[2] !== 3'd1 || req_ready[2] !== 1'b1 || resp_rdata[2] !== 64'd0) begin
            failures++;
            $display("FAIL async_reset got v=%b stat=%0d rdy=%b data=%h exp v=0 stat=1 rdy=1 data=0",
                     resp_valid[2], stat[2], req_ready[2], resp_rdata[2]);
        end
        mdl_stat[2] = 3'd1;
        repeat (5) @(negedge clk);
        checks++;
        if (resp_valid[2] !== 1'b0) begin
            failures++;
            $display("FAIL dropped_resp got v=%b exp v=0", resp_valid[2]);
        end
        rst = 1'b0;
        txn(2, 1'b0, 64'h10, 64'd0, 4'd5, 1'b1, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            int d, sel;
            logic [63:0] a;
            if (n % 25 == 24) apply_reset();
            d = $urandom_range(0, ND - 1);
            sel = $urandom_range(0, 7);
            a = (sel == 0) ? (($urandom_range(0, 1) == 1) ? {1'b1, 31'($urandom), 32'($urandom)}
                                                          : 64'(DEPTH) * 8 + 64'($urandom_range(0, 4095)))
                           : {55'd0, 6'($urandom_range(0, 63)), (sel == 1) ? 3'($urandom_range(1, 7)) : 3'd0};
            txn(d, 1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill();
        test_basic();
        test_stall();
        test_oob();
        test_ins();
        test_align();
        test_reset_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
